// File: rtl/bus_copy_master_if.sv
// Request/acknowledge bus between a copy master and a memory responder.
// The master drives address, rq, wr_ni and dataW. The responder answers
// with a one-cycle ack and supplies dataR in that same cycle.
interface bus_copy_master_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  rq;
   logic                  ack;
   logic                  wr_ni;
   logic [DATA_WIDTH-1:0] dataW;
   logic [DATA_WIDTH-1:0] dataR;

   modport master (
      output address, rq, wr_ni, dataW,
      input  ack, dataR
   );

   modport slave (
      input  address, rq, wr_ni, dataW,
      output ack, dataR
   );
endinterface

// File: rtl/bus_copy_master.sv
// Block-copy bus master.
// Copies `length` words from src_addr.. to dst_addr.. one word at a time.
// Each word is a single read followed by a single write. The request line
// always drops for one idle cycle between transactions, so a one-cycle ack
// cannot be counted twice. A request left unanswered for TIMEOUT cycles
// abandons the copy and sets the sticky error flag.
module bus_copy_master #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   bus_copy_master_if.master     bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, READ, GAP_R, WRITE, GAP_W, FINISH
   } state_t;

   state_t                state_reg,   state_next;
   logic [ADDR_WIDTH-1:0] src_reg,     src_next;
   logic [ADDR_WIDTH-1:0] dst_reg,     dst_next;
   logic [ADDR_WIDTH-1:0] len_reg,     len_next;
   logic [ADDR_WIDTH-1:0] index_reg,   index_next;
   logic [DATA_WIDTH-1:0] buffer_reg,  buffer_next;
   logic [TW-1:0]         timer_reg,   timer_next;
   logic                  rq_reg,      rq_next;
   logic                  wr_ni_reg,   wr_ni_next;
   logic [ADDR_WIDTH-1:0] address_reg, address_next;
   logic [DATA_WIDTH-1:0] dataw_reg,   dataw_next;
   logic                  busy_reg,    busy_next;
   logic                  done_reg,    done_next;
   logic                  error_reg,   error_next;

   logic [ADDR_WIDTH-1:0] index_inc;
   logic                  timeout_hit;

   assign index_inc   = index_reg + ADDR_WIDTH'(1);
   // The request has been held TIMEOUT-1 cycles. One more cycle without ack aborts it.
   assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));

   // Next-state and next-output logic. Every register holds its value unless a case below updates it.
   always_comb begin
      state_next   = state_reg;
      src_next     = src_reg;
      dst_next     = dst_reg;
      len_next     = len_reg;
      index_next   = index_reg;
      buffer_next  = buffer_reg;
      timer_next   = timer_reg;
      rq_next      = rq_reg;
      wr_ni_next   = wr_ni_reg;
      address_next = address_reg;
      dataw_next   = dataw_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      error_next   = error_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               error_next = 1'b0;
               if (length != '0) begin
                  src_next     = src_addr;
                  dst_next     = dst_addr;
                  len_next     = length;
                  index_next   = '0;
                  busy_next    = 1'b1;
                  rq_next      = 1'b1;
                  wr_ni_next   = 1'b0;
                  address_next = src_addr;
                  timer_next   = '0;
                  state_next   = READ;
               end else begin
                  done_next  = 1'b1;
                  state_next = FINISH;
               end
            end
         end

         READ: begin
            if (bus.ack) begin
               buffer_next = bus.dataR;
               rq_next     = 1'b0;
               state_next  = GAP_R;
            end else if (timeout_hit) begin
               rq_next    = 1'b0;
               error_next = 1'b1;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = FINISH;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end

         GAP_R: begin
            rq_next      = 1'b1;
            wr_ni_next   = 1'b1;
            address_next = dst_reg + index_reg;
            dataw_next   = buffer_reg;
            timer_next   = '0;
            state_next   = WRITE;
         end

         WRITE: begin
            if (bus.ack) begin
               rq_next    = 1'b0;
               index_next = index_inc;
               if (index_inc == len_reg) begin
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
                  state_next = FINISH;
               end else begin
                  state_next = GAP_W;
               end
            end else if (timeout_hit) begin
               rq_next    = 1'b0;
               error_next = 1'b1;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = FINISH;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end

         GAP_W: begin
            rq_next      = 1'b1;
            wr_ni_next   = 1'b0;
            address_next = src_reg + index_reg;
            timer_next   = '0;
            state_next   = READ;
         end

         FINISH: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers. The asynchronous reset drops the bus request immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         src_reg     <= '0;
         dst_reg     <= '0;
         len_reg     <= '0;
         index_reg   <= '0;
         buffer_reg  <= '0;
         timer_reg   <= '0;
         rq_reg      <= 1'b0;
         wr_ni_reg   <= 1'b0;
         address_reg <= '0;
         dataw_reg   <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         src_reg     <= src_next;
         dst_reg     <= dst_next;
         len_reg     <= len_next;
         index_reg   <= index_next;
         buffer_reg  <= buffer_next;
         timer_reg   <= timer_next;
         rq_reg      <= rq_next;
         wr_ni_reg   <= wr_ni_next;
         address_reg <= address_next;
         dataw_reg   <= dataw_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         error_reg   <= error_next;
      end
   end

   assign bus.rq      = rq_reg;
   assign bus.wr_ni   = wr_ni_reg;
   assign bus.address = address_reg;
   assign bus.dataW   = dataw_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign error       = error_reg;

endmodule
